// File: rtl/dds_period_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dds_period_detector                                                      |
// | Hysteretic rising-zero-crossing period meter with lock tracking and a    |
// | valid/ready period output. Optional FSK decode: DDS_PERIOD_FSK_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dds_period_detector #(
  parameter int PW     = 12,
  parameter int HYST   = 16,
  parameter int LOCK_N = 4,
  parameter int TOL    = 1
`ifdef DDS_PERIOD_FSK_EN
  ,
  parameter int FSK_THRESH = 200
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [8:0]    sample_in,
  input  logic          sample_valid,
  output logic [PW-1:0] period_out,
  output logic          period_valid,
  input  logic          period_ready,
  output logic          locked,
  output logic          timeout,
  output logic          overrun
`ifdef DDS_PERIOD_FSK_EN
  ,
  output logic          fsk_bit,
  output logic          fsk_valid
`endif
);

  localparam int MW = $clog2(LOCK_N + 1);

  localparam logic [1:0] c_st_seek     = 2'd0;
  localparam logic [1:0] c_st_arm0     = 2'd1;
  localparam logic [1:0] c_st_wait_neg = 2'd2;
  localparam logic [1:0] c_st_wait_pos = 2'd3;

  localparam logic signed [9:0] c_hyst_pos = 10'(HYST);
  localparam logic signed [9:0] c_hyst_neg = -c_hyst_pos;
  localparam logic [PW-1:0]     c_cnt_max  = '1;
  localparam logic [PW-1:0]     c_cnt_one  = PW'(1);
  localparam logic [PW:0]       c_tol      = (PW+1)'(TOL);
  localparam logic [MW-1:0]     c_lock_n   = MW'(LOCK_N);
  localparam logic [MW-1:0]     c_mcnt_one = MW'(1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] prev_q, prev_d;
  logic          have_prev_q, have_prev_d;
  logic [MW-1:0] match_q, match_d;
  logic          locked_q, locked_d;
  logic [PW-1:0] period_out_q;
  logic          period_valid_q;
  logic          timeout_q;
  logic          overrun_q;

  logic signed [9:0] w_smp;
  logic              w_neg;
  logic              w_pos;
  logic              w_cnt_sat;
  logic              w_done;
  logic              w_tmo;
  logic [PW:0]       w_diff;
  logic [PW:0]       w_absdiff;
  logic              w_match;
  logic              w_load;
  logic              w_drop;

  assign w_smp     = $signed({sample_in[8], sample_in});
  assign w_neg     = sample_valid && (w_smp <= c_hyst_neg);
  assign w_pos     = sample_valid && (w_smp >= c_hyst_pos);
  assign w_cnt_sat = (cnt_q == c_cnt_max);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= c_st_seek;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a saturated counter wins over arming, a rising crossing wins over saturation
  always_comb begin
    state_d = state_q;
    if (sample_valid) begin
      case (state_q)
        c_st_seek:     if (w_neg) state_d = c_st_arm0;
        c_st_arm0:     if (w_pos) state_d = c_st_wait_neg;
        c_st_wait_neg: begin
          if (w_cnt_sat)  state_d = c_st_seek;
          else if (w_neg) state_d = c_st_wait_pos;
        end
        c_st_wait_pos: begin
          if (w_pos)          state_d = c_st_wait_neg;
          else if (w_cnt_sat) state_d = c_st_seek;
        end
        default:       state_d = c_st_seek;
      endcase
    end
  end

  // FSM outputs: sample counter, period completion and timeout events
  always_comb begin
    cnt_d  = cnt_q;
    w_done = 1'b0;
    w_tmo  = 1'b0;
    if (sample_valid) begin
      case (state_q)
        c_st_arm0: begin
          if (w_pos) cnt_d = c_cnt_one;
        end
        c_st_wait_neg: begin
          if (w_cnt_sat) begin
            w_tmo = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        c_st_wait_pos: begin
          if (w_pos) begin
            w_done = 1'b1;
            cnt_d  = c_cnt_one;
          end else if (w_cnt_sat) begin
            w_tmo = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  assign w_diff    = {1'b0, cnt_q} - {1'b0, prev_q};
  assign w_absdiff = w_diff[PW] ? -w_diff : w_diff;
  assign w_match   = (w_absdiff <= c_tol);

  // Lock tracking sees every completed period, including ones the output drops
  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_d     = match_q;
    locked_d    = locked_q;
    if (w_tmo) begin
      have_prev_d = 1'b0;
      match_d     = '0;
      locked_d    = 1'b0;
    end else if (w_done) begin
      prev_d      = cnt_q;
      have_prev_d = 1'b1;
      if (have_prev_q) begin
        if (!w_match)                match_d = '0;
        else if (match_q != c_lock_n) match_d = match_q + c_mcnt_one;
      end
      locked_d = (match_d == c_lock_n);
    end
  end

  assign w_load = w_done && (!period_valid_q || period_ready);
  assign w_drop = w_done && period_valid_q && !period_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q          <= '0;
      prev_q         <= '0;
      have_prev_q    <= 1'b0;
      match_q        <= '0;
      locked_q       <= 1'b0;
      period_out_q   <= '0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
      locked_q    <= locked_d;
      timeout_q   <= w_tmo;
      if (w_load) begin
        period_out_q   <= cnt_q;
        period_valid_q <= 1'b1;
      end else if (period_valid_q && period_ready) begin
        period_valid_q <= 1'b0;
      end
      if (w_drop) overrun_q <= 1'b1;
    end
  end

  assign period_out   = period_out_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;
  assign overrun      = overrun_q;

`ifdef DDS_PERIOD_FSK_EN
  logic fsk_bit_q;
  logic fsk_valid_q;
  logic w_fsk_short;

  assign w_fsk_short = ({{(32-PW){1'b0}}, cnt_q} < 32'(FSK_THRESH));

  // Decision uses the lock state held before this period updates it
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsk_bit_q   <= 1'b0;
      fsk_valid_q <= 1'b0;
    end else begin
      fsk_valid_q <= w_done && locked_q;
      if (w_done && locked_q) fsk_bit_q <= w_fsk_short;
    end
  end

  assign fsk_bit   = fsk_bit_q;
  assign fsk_valid = fsk_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dds_period_detector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dds_period_detector                                                   |
// | Randomized sine/noise stimulus against a sample-index reference model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dds_period_detector;

  localparam int PW     = 12;
  localparam int HYST   = 16;
  localparam int LOCK_N = 4;
  localparam int TOL    = 1;
  localparam int CMAX   = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [8:0]    sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          period_ready = 1'b0;
  logic [PW-1:0] period_out;
  logic          period_valid;
  logic          locked;
  logic          timeout;
  logic          overrun;
`ifdef DDS_PERIOD_FSK_EN
  logic          fsk_bit;
  logic          fsk_valid;
`endif

  dds_period_detector #(.PW(PW), .HYST(HYST), .LOCK_N(LOCK_N), .TOL(TOL)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .period_out   (period_out),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .locked       (locked),
    .timeout      (timeout),
    .overrun      (overrun)
`ifdef DDS_PERIOD_FSK_EN
    ,
    .fsk_bit      (fsk_bit),
    .fsk_valid    (fsk_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: crossings tracked by sample index, not by a counter FSM
  int m_active, m_armed, m_idx, m_cross_idx;
  int m_has_prev, m_prev, m_match;
  int m_pv, m_po, m_locked, m_tmo, m_ovr, m_fb, m_fv;
  int g_ph;
  int tmo_cnt, pv_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_active = 0; m_armed = 0; m_idx = 0; m_cross_idx = 0;
    m_has_prev = 0; m_prev = 0; m_match = 0;
    m_pv = 0; m_po = 0; m_locked = 0; m_tmo = 0; m_ovr = 0; m_fb = 0; m_fv = 0;
  endtask

  task automatic model_step(input int s, input int v, input int rdy);
    int done, tmo, p, k, d;
    done = 0; tmo = 0; p = 0;
    if (v != 0) begin
      m_idx++;
      k = m_idx - m_cross_idx;
      if (s >= HYST && m_armed != 0) begin
        if (m_active != 0) begin
          done = 1;
          p = k;
        end
        m_active = 1; m_armed = 0; m_cross_idx = m_idx;
      end else if (m_active != 0 && k >= CMAX) begin
        tmo = 1; m_active = 0; m_armed = 0;
      end else if (s <= -HYST) begin
        m_armed = 1;
      end
    end
    m_fv = (done != 0 && m_locked != 0) ? 1 : 0;
    if (m_fv != 0) m_fb = (p < 200) ? 1 : 0;
    if (tmo != 0) begin
      m_has_prev = 0; m_match = 0; m_locked = 0;
    end else if (done != 0) begin
      if (m_has_prev != 0) begin
        d = (p > m_prev) ? p - m_prev : m_prev - p;
        if (d <= TOL) m_match = (m_match < LOCK_N) ? m_match + 1 : LOCK_N;
        else m_match = 0;
      end
      m_has_prev = 1;
      m_prev = p;
      m_locked = (m_match == LOCK_N) ? 1 : 0;
    end
    if (done != 0 && (m_pv == 0 || rdy != 0)) begin
      m_po = p; m_pv = 1;
    end else if (done != 0) begin
      m_ovr = 1;
    end else if (m_pv != 0 && rdy != 0) begin
      m_pv = 0;
    end
    m_tmo = tmo;
  endtask

  task automatic compare_all();
    chk("period_valid", int'(period_valid), m_pv);
    chk("period_out", int'(period_out), m_po);
    chk("locked", int'(locked), m_locked);
    chk("timeout", int'(timeout), m_tmo);
    chk("overrun", int'(overrun), m_ovr);
`ifdef DDS_PERIOD_FSK_EN
    chk("fsk_valid", int'(fsk_valid), m_fv);
    chk("fsk_bit", int'(fsk_bit), m_fb);
`endif
    if (timeout) tmo_cnt++;
    if (period_valid) pv_cnt++;
  endtask

  task automatic step(input int s_in, input int v, input int rdy);
    int s;
    s = (s_in > 255) ? 255 : ((s_in < -256) ? -256 : s_in);
    rst = 1'b1;
    sample_in = s[8:0];
    sample_valid = (v != 0);
    period_ready = (rdy != 0);
    @(posedge clk);
    model_step(s, v, rdy);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sample_valid = 1'($urandom_range(1));
    period_ready = 1'($urandom_range(1));
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
    chk("rst_period_valid", int'(period_valid), 0);
    tmo_cnt = 0;
    pv_cnt = 0;
  endtask

  function automatic int sine(input int ph, input int n, input int amp);
    return $rtoi(real'(amp) * $sin(6.283185307179586 * real'(ph % n) / real'(n)));
  endfunction

  // rdy_mode: 0 = held low, 1 = held high, 2 = random
  task automatic run_sine(input int n, input int nsamp, input int amp,
                          input int vpct, input int rdy_mode, input int noise);
    int v, rdy, s;
    for (int i = 0; i < nsamp; i++) begin
      v   = ($urandom_range(99) < vpct) ? 1 : 0;
      rdy = (rdy_mode == 2) ? int'($urandom_range(1)) : rdy_mode;
      if (v != 0) s = sine(g_ph, n, amp) + int'($urandom_range(2*noise)) - noise;
      else        s = int'($urandom_range(511)) - 256;
      step(s, v, rdy);
      if (v != 0) g_ph++;
    end
  endtask

  initial begin
    model_reset();
    tmo_cnt = 0;
    pv_cnt = 0;
    do_reset();
    chk("rst_locked", int'(locked), 0);
    chk("rst_period_out", int'(period_out), 0);

    // Clean 256-sample sine, always ready
    g_ph = int'($urandom_range(255));
    run_sine(256, 256*9, 200, 100, 1, 0);
    chk("lock_256", int'(locked), 1);
    chk("period_256", int'(period_out), 256);
    chk("no_overrun", int'(overrun), 0);

    // Back-pressure for three periods, then release
    run_sine(256, 256*3, 200, 100, 0, 0);
    chk("held_valid", int'(period_valid), 1);
    chk("held_period", int'(period_out), 256);
    chk("overrun_set", int'(overrun), 1);
    run_sine(256, 300, 200, 100, 1, 0);
    chk("fresh_period", int'(period_out), 256);

    // Sub-hysteresis noise never produces a crossing
    do_reset();
    for (int i = 0; i < 600; i++) step(int'($urandom_range(30)) - 15, 1, 1);
    chk("noise_no_valid", pv_cnt, 0);

    // Flat line after one crossing saturates the counter
    do_reset();
    for (int i = 0; i < 5; i++) step(-100, 1, 1);
    for (int i = 0; i < CMAX + 100; i++) step(100, 1, 1);
    chk("timeout_once", tmo_cnt, 1);
    chk("timeout_unlocked", int'(locked), 0);

    // Frequency step 256 -> 128
    do_reset();
    run_sine(256, 256*8, 200, 100, 1, 0);
    chk("lock_before_step", int'(locked), 1);
    run_sine(128, 128*10, 200, 100, 1, 0);
    chk("lock_128", int'(locked), 1);
    chk("period_128", int'(period_out), 128);

    // Reset while a period is held and a measurement is in flight
    run_sine(128, 128*2 + 40 + int'($urandom_range(40)), 200, 100, 0, 0);
    do_reset();
    chk("rst_overrun", int'(overrun), 0);
    run_sine(128, 128*8, 200, 100, 1, 0);

    // Randomized periods, gaps, back-pressure and noise
    for (int r = 0; r < 6; r++) begin
      do_reset();
      run_sine(int'($urandom_range(300, 40)), 1500, int'($urandom_range(250, 60)),
               int'($urandom_range(100, 70)), 2, int'($urandom_range(8)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
